// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   S_IDLE / S_RUN / S_DONE : raw state codes
//   state_e                 : typed FSM state built on those codes
package serial_add_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell shared by the serial adder controller.
// Ports:
//   A, B, Cin : addend bits and carry-in
//   Sum       : A ^ B ^ Cin
//   Carry     : carry-out (majority of A, B, Cin)
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first through
// a single full_adder cell, one bit per clock, with a start/busy/done handshake.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : request, sampled only in IDLE or DONE
//   A, B, Cin : operands and carry-in, captured on the accepted start edge
//   busy      : high while bits are being processed
//   done      : one-cycle pulse when Sum/Carry carry a new result
//   Sum,Carry : registered result, updated only when a run completes
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cflop_q, cflop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_shift;

  full_adder u_fa (
    .A     (opa_q[0]),
    .B     (opb_q[0]),
    .Cin   (cflop_q),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the first
  // (LSB) bit has reached position 0.
  assign res_shift = {fa_sum, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cflop_d = cflop_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          opa_d   = A;
          opb_d   = B;
          cflop_d = Cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_shift;
        cflop_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = res_shift;
          carry_d = fa_carry;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of the next state, so they line up
    // with the state they describe and can never be high together.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cflop_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cflop_q <= cflop_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Carry (carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH:0] res;
    int             acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
    int unsigned total;
    total = int'(x) + int'(y) + int'(c);
    return (WIDTH+1)'(total % (1 << (WIDTH + 1)));
  endfunction

  // Issue one add: waits until the controller can accept, holds start for
  // the accepting edge, records the expected response. Called at posedge+1.
  task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ic);
    int g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) begin
      flag_timeout("issue_wait");
      return;
    end
    a = ia; b = ib; cin = ic; start = 1'b1;
    exp_q.push_back('{res: ref_add(ia, ib, ic), acc_edge: cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || done || exp_q.size() != 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy || done || exp_q.size() != 0) flag_timeout("wait_idle");
  endtask

  // Monitor / scoreboard
  logic [WIDTH:0] last_res = '0;
  int             busy_run = 0;
  logic           prev_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        last_res  = '0;
        busy_run  = 0;
        prev_done = 1'b0;
      end else begin
        exp_t e;
        if (busy) busy_run++;
        chk("busy_done_excl", longint'(busy & done), 0);
        if (done) begin
          chk("done_width", longint'(prev_done), 0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: done=1 with no accepted start (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("sum", longint'(sum), longint'(e.res[WIDTH-1:0]));
            chk("carry", longint'(carry), longint'(e.res[WIDTH]));
            chk("latency", longint'(cyc), longint'(e.acc_edge + WIDTH));
            chk("busy_cycles", longint'(busy_run), WIDTH);
            last_res = e.res;
          end
          busy_run = 0;
        end else begin
          chk("result_hold", longint'({carry, sum}), longint'(last_res));
        end
        prev_done = done;
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_carry", longint'(carry), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed sums
    issue(8'h0F, 8'h01, 1'b0);
    wait_idle();
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    // start during RUN must be ignored
    issue(8'h10, 8'h20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("run_busy_before_ignored_start", longint'(busy), 1);
    a = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-run
    issue(8'h37, 8'h44, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_sum", longint'(sum), 8'h30);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_sum", longint'(sum), 0);
    chk("abort_carry", longint'(carry), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_abort_idle", longint'(busy | done), 0);
    issue(8'h01, 8'h01, 1'b0);
    wait_idle();

    // Back-to-back with start held across DONE
    issue(8'h12, 8'h34, 1'b0);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) flag_timeout("b2b_wait");
    else begin
      chk("b2b_done_seen", longint'(done), 1);
      exp_q.push_back('{res: ref_add(8'h80, 8'h80, 1'b0), acc_edge: cyc + 1});
      @(posedge clk); #1;
      chk("b2b_no_idle", longint'(busy), 1);
    end
    start = 1'b0;
    wait_idle();

    // Randomized operand triples with random idle gaps
    for (int i = 0; i < 200; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      rc = 1'($urandom());
      issue(ra, rb, rc);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Idle tail: any done here would be unmatched
    repeat (12) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
